// File: rtl/config_pkg.sv
// Shared constants, field-offset helpers and FSM state type for the
// config-flit router.
package config_pkg;

  localparam logic [2:0] FT_WR  = 3'b100;
  localparam logic [2:0] FT_RD  = 3'b101;
  localparam logic [2:0] FT_RSP = 3'b110;
  localparam logic [2:0] FT_ERR = 3'b111;

  // Default field geometry (data | addr | target | pad | type, LSB first)
  localparam int CDW_DEF  = 21;
  localparam int CAW_DEF  = 15;
  localparam int ATW_DEF  = 3;
  localparam int FW_DEF   = 59;
  localparam int FTW_DEF  = 3;
  localparam int ADDR_LSB = CDW_DEF;
  localparam int TGT_LSB  = CDW_DEF + CAW_DEF;
  localparam int TYPE_LSB = FW_DEF - FTW_DEF;

  // Offsets for non-default geometries
  function automatic int addr_lsb(int cdw);
    return cdw;
  endfunction

  function automatic int tgt_lsb(int cdw, int caw);
    return cdw + caw;
  endfunction

  function automatic int type_lsb(int fw, int ftw);
    return fw - ftw;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_WAIT,
    S_RSP
  } cr_state_e;

endpackage

// File: rtl/config_fifo.sv
// Synchronous FD x FW flit FIFO. A push into a full FIFO is accepted when a
// pop happens in the same cycle; otherwise it is dropped and ovf pulses.
module config_fifo #(
  parameter int FW = 59,
  parameter int FD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [FW-1:0] din,
  input  logic          pop,
  output logic [FW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic          ovf
);

  localparam int AW = (FD > 1) ? $clog2(FD) : 1;

  logic [FW-1:0] mem [FD];
  logic [AW:0]   wp, rp;
  logic          do_push, do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf     = push && full && !do_pop;
  assign head    = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/config_router.sv
// Decodes config flits into per-target write/read strobes and returns read
// data (or an error for unknown targets) as response flits.
module config_router
  import config_pkg::*;
#(
  parameter int FW  = 59,
  parameter int FTW = 3,
  parameter int ATW = 3,
  parameter int CAW = 15,
  parameter int CDW = 21,
  parameter int NT  = 4,
  parameter int FD  = 4,
  parameter int RL  = 1
) (
  input  logic              clk_config,
  input  logic              rst,
  input  logic              spk_in_config_we,
  input  logic [FW-1:0]     spk_in_config_wdata,
  output logic              config_spk_in_credit,
  input  logic [NT-1:0]     tgt_busy,
  output logic [NT-1:0]     cfg_we,
  output logic [CAW-1:0]    cfg_waddr,
  output logic [CDW-1:0]    cfg_wdata,
  output logic [NT-1:0]     cfg_re,
  output logic [CAW-1:0]    cfg_raddr,
  input  logic [NT*CDW-1:0] cfg_rdata,
  input  logic              spk_out_conifg_full,
  output logic              config_spk_out_we,
  output logic [FW-1:0]     config_spk_out_wdata,
  output logic              ovf_err
);

  localparam int A_LSB = addr_lsb(CDW);
  localparam int T_LSB = tgt_lsb(CDW, CAW);
  localparam int Y_LSB = type_lsb(FW, FTW);
  localparam int CW    = (RL > 1) ? $clog2(RL) : 1;

  logic [FW-1:0]  head;
  logic           fifo_full, fifo_empty, fifo_ovf, pop;

  config_fifo #(.FW(FW), .FD(FD)) u_fifo (
    .clk   (clk_config),
    .rst   (rst),
    .push  (spk_in_config_we),
    .din   (spk_in_config_wdata),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .ovf   (fifo_ovf)
  );

  logic [FTW-1:0] h_type;
  logic [ATW-1:0] h_tgt;
  logic [CAW-1:0] h_addr;
  logic [CDW-1:0] h_data;
  logic           h_ok, h_busy;
  logic [NT-1:0]  h_oh;

  assign h_type = head[Y_LSB +: FTW];
  assign h_tgt  = head[T_LSB +: ATW];
  assign h_addr = head[A_LSB +: CAW];
  assign h_data = head[CDW-1:0];
  assign h_ok   = ({1'b0, h_tgt} < (ATW+1)'(NT));

  generate
    if (Y_LSB > T_LSB + ATW) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^head[Y_LSB-1:T_LSB+ATW];
    end
  endgenerate

  cr_state_e      st, st_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [ATW-1:0] tgt_q, tgt_n;
  logic [CAW-1:0] addr_q, addr_n;
  logic [CDW-1:0] wd_q, wd_n, q_rdata;
  logic [NT-1:0]  we_q, we_n, re_q, re_n;
  logic           cred_q, owe_q, owe_n, ovf_q;
  logic [FW-1:0]  flit_q, flit_n;

  function automatic logic [FW-1:0] mk_flit(logic [FTW-1:0] ty, logic [ATW-1:0] t,
                                            logic [CAW-1:0] a, logic [CDW-1:0] d);
    logic [FW-1:0] f;
    f = '0;
    f[Y_LSB +: FTW] = ty;
    f[T_LSB +: ATW] = t;
    f[A_LSB +: CAW] = a;
    f[CDW-1:0]      = d;
    return f;
  endfunction

  always_comb begin
    h_busy = 1'b0;
    h_oh   = '0;
    for (int i = 0; i < NT; i++) begin
      if (h_tgt == ATW'(i)) begin
        h_busy  = tgt_busy[i];
        h_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    q_rdata = '0;
    for (int i = 0; i < NT; i++) begin
      if (tgt_q == ATW'(i)) q_rdata = cfg_rdata[i*CDW +: CDW];
    end
  end

  // Response we is registered, so it reflects full as seen one cycle earlier.
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    tgt_n  = tgt_q;
    addr_n = addr_q;
    wd_n   = wd_q;
    we_n   = '0;
    re_n   = '0;
    owe_n  = 1'b0;
    flit_n = flit_q;
    pop    = 1'b0;
    case (st)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (!h_ok) begin
            pop = 1'b1;
            if (h_type == FTW'(FT_RD)) begin
              flit_n = mk_flit(FTW'(FT_ERR), h_tgt, h_addr, '0);
              owe_n  = !spk_out_conifg_full;
              st_n   = S_RSP;
            end
          end else if (!h_busy) begin
            pop    = 1'b1;
            tgt_n  = h_tgt;
            addr_n = h_addr;
            wd_n   = h_data;
            if (h_type == FTW'(FT_WR)) begin
              we_n = h_oh;
              st_n = S_WR;
            end else if (h_type == FTW'(FT_RD)) begin
              re_n = h_oh;
              st_n = S_RD;
            end
          end
        end
      end
      S_WR: st_n = S_IDLE;
      S_RD: begin
        cnt_n = '0;
        st_n  = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == CW'(RL-1)) begin
          flit_n = mk_flit(FTW'(FT_RSP), tgt_q, addr_q, q_rdata);
          owe_n  = !spk_out_conifg_full;
          st_n   = S_RSP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_RSP: begin
        if (owe_q) st_n = S_IDLE;
        else       owe_n = !spk_out_conifg_full;
      end
      default: st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_config) begin
    if (rst) begin
      st     <= S_IDLE;
      cnt    <= '0;
      tgt_q  <= '0;
      addr_q <= '0;
      wd_q   <= '0;
      we_q   <= '0;
      re_q   <= '0;
      cred_q <= 1'b0;
      owe_q  <= 1'b0;
      flit_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      tgt_q  <= tgt_n;
      addr_q <= addr_n;
      wd_q   <= wd_n;
      we_q   <= we_n;
      re_q   <= re_n;
      cred_q <= pop;
      owe_q  <= owe_n;
      flit_q <= flit_n;
      ovf_q  <= ovf_q | fifo_ovf;
    end
  end

  assign cfg_we               = we_q;
  assign cfg_waddr            = addr_q;
  assign cfg_wdata            = wd_q;
  assign cfg_re               = re_q;
  assign cfg_raddr            = addr_q;
  assign config_spk_in_credit = cred_q;
  assign config_spk_out_we    = owe_q;
  assign config_spk_out_wdata = flit_q;
  assign ovf_err              = ovf_q;

endmodule

// File: tb/tb_config_router.sv
// Scoreboard bench for config_router: stimulus pushes expected commands and
// responses; a negedge monitor pops and compares whatever the DUT emits.
module tb_config_router;

  localparam int FW = 59, FTW = 3, ATW = 3, CAW = 15, CDW = 21;
  localparam int NT = 4, FD = 4, RL = 1;
  localparam int A_LSB = CDW, T_LSB = CDW + CAW, Y_LSB = FW - FTW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_we = 1'b0;
  logic [FW-1:0] in_flit = '0;
  logic credit;
  logic [NT-1:0] tgt_busy, dir_busy = '0, rnd_busy = '0;
  logic [NT-1:0] cfg_we, cfg_re;
  logic [CAW-1:0] waddr, raddr;
  logic [CDW-1:0] wdata;
  logic [NT*CDW-1:0] rdata = '0;
  logic full, dir_full = 1'b0, rnd_full = 1'b0;
  logic out_we, ovf;
  logic [FW-1:0] out_flit;
  logic rnd_on = 1'b0;

  assign tgt_busy = dir_busy | rnd_busy;
  assign full     = dir_full | rnd_full;

  always #5 clk = ~clk;

  config_router #(.FW(FW), .FTW(FTW), .ATW(ATW), .CAW(CAW), .CDW(CDW),
                  .NT(NT), .FD(FD), .RL(RL)) dut (
    .clk_config           (clk),
    .rst                  (rst),
    .spk_in_config_we     (in_we),
    .spk_in_config_wdata  (in_flit),
    .config_spk_in_credit (credit),
    .tgt_busy             (tgt_busy),
    .cfg_we               (cfg_we),
    .cfg_waddr            (waddr),
    .cfg_wdata            (wdata),
    .cfg_re               (cfg_re),
    .cfg_raddr            (raddr),
    .cfg_rdata            (rdata),
    .spk_out_conifg_full  (full),
    .config_spk_out_we    (out_we),
    .config_spk_out_wdata (out_flit),
    .ovf_err              (ovf)
  );

  int n_tests = 0, n_fail = 0;
  int cyc = 0, push_cyc = 0;
  int sent = 0, rcvd = 0;
  int we_n = 0, re_n = 0, rsp_n = 0;
  int we_cyc = 0, re_cyc = 0, rsp_cyc = 0, cr_cyc = 0;
  logic [63:0] exp_wr[$], exp_rd[$], exp_rsp[$];
  logic [63:0] mon_e;
  logic prev_full = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Target read data: a fixed function of (target, address), valid RL cycles after re
  function automatic logic [CDW-1:0] tdata(logic [ATW-1:0] t, logic [CAW-1:0] a);
    logic [31:0] v;
    v = ({11'd0, a, 3'd0, t} * 32'd40503) ^ 32'h15A5A;
    return v[CDW-1:0];
  endfunction

  function automatic logic [FW-1:0] mkf(logic [FTW-1:0] ty, logic [ATW-1:0] t,
                                        logic [CAW-1:0] a, logic [CDW-1:0] d);
    logic [FW-1:0] f;
    f = '0;
    f[Y_LSB +: FTW] = ty;
    f[T_LSB +: ATW] = t;
    f[A_LSB +: CAW] = a;
    f[CDW-1:0]      = d;
    return f;
  endfunction

  function automatic logic [ATW-1:0] oh2i(logic [NT-1:0] v);
    logic [ATW-1:0] r;
    r = '0;
    for (int i = 0; i < NT; i++) if (v[i]) r = ATW'(i);
    return r;
  endfunction

  // Reference behaviour of one accepted flit
  task automatic model(logic [FW-1:0] f);
    logic [FTW-1:0] ty;
    logic [ATW-1:0] t;
    logic [CAW-1:0] a;
    logic [CDW-1:0] d;
    ty = f[Y_LSB +: FTW];
    t  = f[T_LSB +: ATW];
    a  = f[A_LSB +: CAW];
    d  = f[CDW-1:0];
    if (ty == 3'b100 && int'(t) < NT) exp_wr.push_back(64'({t, a, d}));
    else if (ty == 3'b101) begin
      if (int'(t) < NT) begin
        exp_rd.push_back(64'({t, a}));
        exp_rsp.push_back(64'(mkf(3'b110, t, a, tdata(t, a))));
      end else
        exp_rsp.push_back(64'(mkf(3'b111, t, a, '0)));
    end
  endtask

  task automatic send(logic [FW-1:0] f);
    int w;
    w = 0;
    while (FD - sent + rcvd <= 0 && w < 1000) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 1000) chk("credit_timeout", 64'(w), 64'd0);
    model(f);
    in_we = 1'b1;
    in_flit = f;
    @(posedge clk); #1;
    push_cyc = cyc;
    in_we = 1'b0;
    sent++;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_wr.size() + exp_rd.size() + exp_rsp.size()) != 0 && w < 20000) begin
      @(posedge clk);
      w++;
    end
    if (w >= 20000) chk("drain_timeout", 64'(exp_wr.size() + exp_rd.size() + exp_rsp.size()), 64'd0);
    repeat (10) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int i = 0; i < NT; i++)
      rdata[i*CDW +: CDW] <= cfg_re[i] ? tdata(ATW'(i), raddr) : CDW'($urandom);
  end

  always @(posedge clk) begin
    if (rnd_on) begin
      rnd_busy <= ($urandom_range(0, 3) == 0) ? NT'($urandom) : '0;
      rnd_full <= ($urandom_range(0, 3) == 0);
    end else begin
      rnd_busy <= '0;
      rnd_full <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (cfg_we != '0) begin
        we_n++;
        we_cyc = cyc;
        if (exp_wr.size() == 0) chk("wr_unexpected", 64'(cfg_we), 64'd0);
        else begin
          mon_e = exp_wr.pop_front();
          chk("wr_cmd", 64'({1'($onehot(cfg_we)), oh2i(cfg_we), waddr, wdata}),
              64'({1'b1, mon_e[ATW+CAW+CDW-1:0]}));
        end
      end
      if (cfg_re != '0) begin
        re_n++;
        re_cyc = cyc;
        if (exp_rd.size() == 0) chk("rd_unexpected", 64'(cfg_re), 64'd0);
        else begin
          mon_e = exp_rd.pop_front();
          chk("rd_cmd", 64'({1'($onehot(cfg_re)), oh2i(cfg_re), raddr}),
              64'({1'b1, mon_e[ATW+CAW-1:0]}));
        end
      end
      if (out_we) begin
        rsp_n++;
        rsp_cyc = cyc;
        chk("rsp_after_full", 64'(prev_full), 64'd0);
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 64'(out_flit), 64'd0);
        else begin
          mon_e = exp_rsp.pop_front();
          chk("rsp_flit", 64'(out_flit), mon_e);
        end
      end
      if (credit) begin
        rcvd++;
        cr_cyc = cyc;
      end
    end
    prev_full = full;
  end

  initial begin
    int b_we, b_re, b_rsp, b_cr;
    logic [FW-1:0] f;
    int t;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", 64'({cfg_we, cfg_re, waddr, raddr, wdata, credit, out_we, ovf}), 64'd0);
    chk("reset_flit", 64'(out_flit), 64'd0);

    // single write
    b_we = we_n;
    send(mkf(3'b100, 3'd2, 15'h0123, 21'h1ABCD));
    drain();
    chk("wr_latency", 64'(we_cyc - push_cyc), 64'd1);
    chk("credit_latency", 64'(cr_cyc - push_cyc), 64'd1);
    chk("wr_one_pulse", 64'(we_n - b_we), 64'd1);
    chk("wr_credit", 64'(rcvd), 64'd1);

    // single read
    b_rsp = rsp_n;
    send(mkf(3'b101, 3'd1, 15'h0042, 21'h0));
    drain();
    chk("re_latency", 64'(re_cyc - push_cyc), 64'd1);
    chk("rsp_latency", 64'(rsp_cyc - push_cyc), 64'(2 + RL));
    chk("rsp_count", 64'(rsp_n - b_rsp), 64'd1);

    // busy target blocks the head and everything behind it
    b_we = we_n; b_re = re_n; b_cr = rcvd;
    dir_busy[1] = 1'b1;
    send(mkf(3'b101, 3'd1, 15'h0777, 21'h0));
    send(mkf(3'b100, 3'd0, 15'h0AAA, 21'h12345));
    repeat (10) @(posedge clk);
    #1;
    chk("busy_no_credit", 64'(rcvd - b_cr), 64'd0);
    chk("busy_no_re", 64'(re_n - b_re), 64'd0);
    chk("hol_no_we", 64'(we_n - b_we), 64'd0);
    dir_busy[1] = 1'b0;
    drain();
    chk("busy_release_credit", 64'(rcvd - b_cr), 64'd2);

    // out-of-range targets
    b_we = we_n; b_re = re_n; b_rsp = rsp_n; b_cr = rcvd;
    send(mkf(3'b101, 3'd5, 15'h0321, 21'h1FFFF));
    send(mkf(3'b100, 3'd6, 15'h0654, 21'h0BEEF));
    drain();
    chk("err_no_re", 64'(re_n - b_re), 64'd0);
    chk("err_no_we", 64'(we_n - b_we), 64'd0);
    chk("err_rsp_count", 64'(rsp_n - b_rsp), 64'd1);
    chk("err_credits", 64'(rcvd - b_cr), 64'd2);

    // fill the FIFO, then push exactly on the pop that frees an entry
    b_cr = rcvd;
    dir_busy[0] = 1'b1;
    for (int i = 0; i < FD; i++) begin
      f = mkf(3'b100, 3'd0, 15'(16'h0200 + i), 21'(i + 7));
      model(f);
      in_we = 1'b1; in_flit = f;
      @(posedge clk); #1;
    end
    f = mkf(3'b100, 3'd0, 15'h02FF, 21'h0ACE);
    model(f);
    in_flit = f;
    dir_busy[0] = 1'b0;
    @(posedge clk); #1;
    in_we = 1'b0;
    sent += FD + 1;
    drain();
    chk("full_pushpop_no_ovf", 64'(ovf), 64'd0);
    chk("full_pushpop_credits", 64'(rcvd - b_cr), 64'(FD + 1));

    // response held back by full, then overflow while the router is stuck
    b_rsp = rsp_n; b_cr = rcvd;
    dir_full = 1'b1;
    send(mkf(3'b101, 3'd3, 15'h0055, 21'h0));
    repeat (7) @(posedge clk);
    #1;
    chk("full_hold", 64'(rsp_n - b_rsp), 64'd0);
    for (int i = 0; i <= FD; i++) begin
      f = mkf(3'b100, 3'd0, 15'(16'h0100 + i), 21'(i + 1));
      if (i < FD) model(f);
      in_we = 1'b1; in_flit = f;
      @(posedge clk); #1;
    end
    in_we = 1'b0;
    sent += FD;
    @(negedge clk);
    chk("ovf_set", 64'(ovf), 64'd1);
    chk("full_hold_long", 64'(rsp_n - b_rsp), 64'd0);
    dir_full = 1'b0;
    drain();
    chk("full_release_rsp", 64'(rsp_n - b_rsp), 64'd1);
    chk("ovf_sticky", 64'(ovf), 64'd1);
    chk("ovf_credits", 64'(rcvd - b_cr), 64'(FD + 1));

    // reset while waiting on read data
    send(mkf(3'b101, 3'd2, 15'h0999, 21'h0));
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_wait_outs", 64'({cfg_we, cfg_re, waddr, raddr, wdata, credit, out_we, ovf}), 64'd0);
    chk("rst_wait_flit", 64'(out_flit), 64'd0);
    exp_wr.delete(); exp_rd.delete(); exp_rsp.delete();
    sent = 0; rcvd = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    b_we = we_n; b_rsp = rsp_n;
    send(mkf(3'b100, 3'd1, 15'h0444, 21'h00321));
    drain();
    chk("post_rst_wr_latency", 64'(we_cyc - push_cyc), 64'd1);
    chk("post_rst_wr_count", 64'(we_n - b_we), 64'd1);
    chk("post_rst_no_stale_rsp", 64'(rsp_n - b_rsp), 64'd0);

    // randomized traffic with random busy and full back-pressure
    rnd_on = 1'b1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: f[2:0] = 3'b100;
        4, 5, 6, 7: f[2:0] = 3'b101;
        8:          f[2:0] = 3'b110;
        default:    f[2:0] = 3'($urandom_range(0, 3));
      endcase
      t = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      f = mkf(f[2:0], ATW'(t), CAW'($urandom), CDW'($urandom));
      f[Y_LSB-1:T_LSB+ATW] = (Y_LSB - T_LSB - ATW)'($urandom);
      send(f);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end
    rnd_on = 1'b0;
    drain();
    chk("rand_credit_balance", 64'(rcvd), 64'(sent));
    chk("rand_queues_empty", 64'(exp_wr.size() + exp_rd.size() + exp_rsp.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete, %0d tests so far", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
